// File: rtl/zone_alarm_ctrl.sv
// Multi-zone intrusion alarm sequencer: code-armed exit delay, entry delay on
// designated zones, immediate alarm on other zones, wrong-code lockout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DISARMED | idle, waiting for a good code to start the exit delay
// EXIT     | exit delay running, motion and bad codes ignored
// ARMED    | watching masked zones and counting wrong codes
// ENTRY    | entry delay running, good code required before expiry
// ALARM    | siren on, latching every zone that reports motion
module zone_alarm_ctrl #(
    parameter int                 ZONES      = 4,
    parameter int                 CODE_W     = 4,
    parameter logic [CODE_W-1:0]  CODE       = 4'hA,
    parameter int                 EXIT_DLY   = 8,
    parameter int                 ENTRY_DLY  = 16,
    parameter int                 MAX_FAIL   = 3,
    parameter logic [ZONES-1:0]   ENTRY_MASK = 4'b0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CODE_W-1:0] code,
    input  logic [ZONES-1:0]  mov,
    input  logic [ZONES-1:0]  zone_en,
    output logic [2:0]        state,
    output logic [ZONES-1:0]  alarm_zones,
    output logic [3:0]        fail_cnt,
    output logic              siren
);

    localparam int MAX_DLY = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
    localparam int CNT_W   = $clog2(MAX_DLY) + 1;
    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DLY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
    localparam logic [4:0]       MAX_F    = 5'(MAX_FAIL);

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    state_t            st;
    logic [CNT_W-1:0]  cnt;
    logic [ZONES-1:0]  mask;
    logic [ZONES-1:0]  entry_zones;

    logic              good;
    logic              bad;
    logic [ZONES-1:0]  active;
    logic [ZONES-1:0]  entry_hit;
    logic [ZONES-1:0]  direct_hit;
    logic [3:0]        fail_inc;
    logic              fail_trip;

    assign good       = enable && (code == CODE);
    assign bad        = enable && (code != CODE);
    assign active     = mov & mask;
    assign entry_hit  = active & ENTRY_MASK;
    assign direct_hit = active & ~ENTRY_MASK;
    assign fail_inc   = (fail_cnt == 4'hF) ? fail_cnt : fail_cnt + 4'd1;
    // Wrong code that brings the consecutive count up to the lockout limit
    assign fail_trip  = bad && (({1'b0, fail_cnt} + 5'd1) >= MAX_F);
    assign state      = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= DISARMED;
            cnt         <= '0;
            mask        <= '0;
            entry_zones <= '0;
            alarm_zones <= '0;
            fail_cnt    <= 4'd0;
            siren       <= 1'b0;
        end else begin
            siren <= 1'b0;
            case (st)
                DISARMED: begin
                    fail_cnt    <= 4'd0;
                    alarm_zones <= '0;
                    if (good) begin
                        st   <= EXIT;
                        cnt  <= EXIT_LD;
                        mask <= zone_en;
                    end
                end
                EXIT: begin
                    if (good) begin
                        st  <= DISARMED;
                        cnt <= '0;
                    end else if (cnt == '0) begin
                        st <= ARMED;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ARMED: begin
                    if (bad) fail_cnt <= fail_inc;
                    if (good) begin
                        st          <= DISARMED;
                        fail_cnt    <= 4'd0;
                        alarm_zones <= '0;
                    end else if (|direct_hit || fail_trip) begin
                        st          <= ALARM;
                        siren       <= 1'b1;
                        alarm_zones <= active;
                    end else if (|entry_hit) begin
                        st          <= ENTRY;
                        cnt         <= ENTRY_LD;
                        entry_zones <= entry_hit;
                    end
                end
                ENTRY: begin
                    if (bad) fail_cnt <= fail_inc;
                    if (good) begin
                        st          <= DISARMED;
                        cnt         <= '0;
                        fail_cnt    <= 4'd0;
                        alarm_zones <= '0;
                    end else if (|direct_hit || fail_trip) begin
                        st          <= ALARM;
                        siren       <= 1'b1;
                        alarm_zones <= active;
                    end else if (cnt == '0) begin
                        // Motion may be gone by timeout; keep the zone that opened the delay
                        st          <= ALARM;
                        siren       <= 1'b1;
                        alarm_zones <= active | entry_zones;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ALARM: begin
                    if (good) begin
                        st          <= DISARMED;
                        fail_cnt    <= 4'd0;
                        alarm_zones <= '0;
                    end else begin
                        siren       <= 1'b1;
                        alarm_zones <= alarm_zones | active;
                        if (bad) fail_cnt <= fail_inc;
                    end
                end
                default: begin
                    st          <= DISARMED;
                    cnt         <= '0;
                    fail_cnt    <= 4'd0;
                    alarm_zones <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/zone_alarm_ctrl.md
ZONE_ALARM_CTRL -- requirements
Module: zone_alarm_ctrl

Interface
Parameters
REQ-001 SHALL have parameter ZONES, default 4: number of motion-sensor zones (1..16).
REQ-002 SHALL have parameter CODE_W, default 4: width of the entered code.
REQ-003 SHALL have parameter CODE, default 4'hA: the valid arm/disarm code.
REQ-004 SHALL have parameter EXIT_DLY, default 8: exit-delay length in cycles (>=1).
REQ-005 SHALL have parameter ENTRY_DLY, default 16: entry-delay length in cycles (>=1).
REQ-006 SHALL have parameter MAX_FAIL, default 3: wrong codes tolerated before alarm (1..15).
REQ-007 SHALL have parameter ENTRY_MASK, default 4'b0001: zones that start the entry delay.

Ports
REQ-008 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-009 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port enable, input, 1 bit: code-valid strobe, sampled only at posedge.
REQ-011 SHALL have port code, input, CODE_W bits: entered code, qualified by enable.
REQ-012 SHALL have port mov, input, ZONES bits: per-zone motion level.
REQ-013 SHALL have port zone_en, input, ZONES bits: zone arming mask.
REQ-014 SHALL have port state, output, 3 bits: 0 DISARMED, 1 EXIT, 2 ARMED, 3 ENTRY, 4 ALARM.
REQ-015 SHALL have port alarm_zones, output, ZONES bits: latched zones that caused the alarm.
REQ-016 SHALL have port fail_cnt, output, 4 bits: count of consecutive wrong codes.
REQ-017 SHALL have port siren, output, 1 bit: registered, high while state is ALARM.

Function
REQ-018 SHALL update all outputs only on the rising clk edge; a strobe is reflected in state one cycle later.
REQ-019 SHALL treat enable=1 with code==CODE as "good" and enable=1 with code!=CODE as "bad".
REQ-020 SHALL latch zone_en into an internal mask on the DISARMED->EXIT transition; the mask is held until DISARMED is re-entered.
REQ-021 SHALL define a zone as active when mov&mask is nonzero; "entry hit" = active&ENTRY_MASK; "direct hit" = active&~ENTRY_MASK.
REQ-022 In DISARMED: good -> EXIT, loading the delay counter with EXIT_DLY-1; bad and mov are ignored; fail_cnt stays 0.
REQ-023 In EXIT: good -> DISARMED; otherwise decrement; counter==0 -> ARMED; mov and bad are ignored.
REQ-024 In ARMED: good -> DISARMED; direct hit -> ALARM; entry hit -> ENTRY, loading the counter with ENTRY_DLY-1; bad -> fail_cnt+1.
REQ-025 In ENTRY: good -> DISARMED; direct hit -> ALARM; otherwise decrement; counter==0 -> ALARM; bad -> fail_cnt+1.
REQ-026 SHALL transition ARMED/ENTRY -> ALARM on the edge where a bad strobe makes fail_cnt reach MAX_FAIL.
REQ-027 In ALARM: good -> DISARMED; bad -> fail_cnt saturating increment at 15; mov ORs newly active zones into alarm_zones.
REQ-028 SHALL give priority to good over any simultaneous hit or counter expiry (disarm wins); a direct hit wins over an entry hit.
REQ-029 SHALL load alarm_zones with the active bits on entry to ALARM; a fail-triggered or entry-timeout alarm loads the active bits, or the ENTRY hit bits for timeout.
REQ-030 SHALL clear fail_cnt and alarm_zones on every transition into DISARMED.
REQ-031 SHALL return any illegal state encoding (5..7) to DISARMED on the next edge.
REQ-032 SHALL make the delay counter $clog2(max(EXIT_DLY,ENTRY_DLY))+1 bits wide; it never wraps below 0.

Reset
REQ-033 On rst=1, regardless of clk: state=0, siren=0, fail_cnt=0, alarm_zones=0, mask=0, counter=0.
REQ-034 Reset asserted mid-delay or mid-alarm SHALL abort immediately; after deassertion the block is in DISARMED and ignores strobes until the first posedge.

Verification
REQ-035 Defaults; good strobe in DISARMED -> state=1 next cycle, then state=2 exactly 8 cycles after the strobe edge; good again -> state=0.
REQ-036 ARMED, zone_en=4'hF; mov=4'b0100 for 1 cycle -> state=4, siren=1, alarm_zones=4'b0100; good -> state=0, alarm_zones=0.
REQ-037 ARMED; mov=4'b0001 -> state=3; no code -> state=4 16 cycles after entry; repeat with good at cycle 10 -> state=0, no alarm.
REQ-038 ARMED; bad strobes x2 -> fail_cnt=2, state=2; 3rd bad -> state=4, fail_cnt=3; good -> state=0, fail_cnt=0.
REQ-039 ARMED; good and mov=4'b0010 in the same cycle -> state=0; zone_en=4'b1110 latched and mov=4'b0001 -> remains ARMED.
REQ-040 rst pulsed asynchronously during EXIT and during ALARM -> all outputs 0 within the pulse, before any clk edge.
